// File: rtl/start_token_consumer.sv
// ---------------------------------------------------------------------------
// start_token_consumer
//
// Consumer-side end of an HLS start-propagation FIFO (start_for_* channel).
// Each start token popped from the FIFO becomes one ap_ctrl_hs launch
// (ap_start/ap_ready) of the downstream PE. Completed invocations are
// tracked through ap_done, and the number of launched-but-not-done
// invocations is capped at MAX_INFLIGHT.
//
// Parameters:
//   DATA_WIDTH    width of the start token carried by the FIFO
//   MAX_INFLIGHT  maximum outstanding invocations (1..15)
//   CNT_WIDTH     width of the in-flight counter (must hold MAX_INFLIGHT)
//
// Ports:
//   clk         clock
//   reset       synchronous active-high reset
//   if_empty_n  FIFO has a token
//   if_read     pop the FIFO this cycle
//   if_dout     FIFO head token
//   ap_start    launch request to the PE
//   ap_ready    PE accepted the launch
//   ap_done     PE finished one invocation (1-cycle pulse)
//   token_out   token of the current/last launch
//   inflight    outstanding invocations
//   idle        no pending launch and nothing in flight
//   err_done    sticky: ap_done seen while nothing was in flight
//
// Optional feature (macro START_TOKEN_CONSUMER_STATS_EN):
//   launch_cnt  free-running count of accepted launches (wraps at 2^32)
//   done_cnt    free-running count of counted completions (wraps at 2^32)
// ---------------------------------------------------------------------------
module start_token_consumer #(
    parameter int unsigned DATA_WIDTH   = 1,
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter int unsigned CNT_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_empty_n,
    output logic                  if_read,
    input  logic [DATA_WIDTH-1:0] if_dout,
    output logic                  ap_start,
    input  logic                  ap_ready,
    input  logic                  ap_done,
    output logic [DATA_WIDTH-1:0] token_out,
    output logic [CNT_WIDTH-1:0]  inflight,
    output logic                  idle,
    output logic                  err_done
`ifdef START_TOKEN_CONSUMER_STATS_EN
    ,
    output logic [31:0]           launch_cnt,
    output logic [31:0]           done_cnt
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        LAUNCH = 1'b1
    } state_t;

    state_t state;

    // One extra bit so inflight + 1 never wraps before the compare.
    localparam logic [CNT_WIDTH:0] MAX_EXT = (CNT_WIDTH + 1)'(MAX_INFLIGHT);

    logic                 launch;
    logic                 done_dec;
    logic [CNT_WIDTH:0]   inflight_ext;
    logic [CNT_WIDTH:0]   done_ext;
    logic [CNT_WIDTH:0]   launch_ext;
    logic [CNT_WIDTH:0]   inflight_next;
    logic                 room;
    logic                 room_after;

    // ap_start is only ever high in LAUNCH, so ap_ready outside a launch
    // is naturally ignored here.
    assign launch   = ap_start && ap_ready;
    // A done with nothing in flight is spurious and never decrements.
    assign done_dec = ap_done && (inflight != '0);

    assign inflight_ext  = {1'b0, inflight};
    assign done_ext      = {{CNT_WIDTH{1'b0}}, done_dec};
    assign launch_ext    = {{CNT_WIDTH{1'b0}}, launch};
    assign inflight_next = inflight_ext + launch_ext - done_ext;

    // Room for a new pop now (IDLE), and room once the launch being
    // accepted this cycle is counted (back-to-back pop in LAUNCH). A done
    // in the same cycle frees a slot immediately.
    assign room       = (inflight_ext - done_ext) < MAX_EXT;
    assign room_after = (inflight_ext + 1'b1 - done_ext) < MAX_EXT;

    // NOTE: every signal assigned in always_comb gets a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        if_read = 1'b0;
        if (!reset) begin
            if (state == IDLE) begin
                if_read = if_empty_n && room;
            end else begin
                if_read = ap_ready && if_empty_n && room_after;
            end
        end
    end

    assign idle = (state == IDLE) && (inflight == '0);

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ap_start  <= 1'b0;
            token_out <= '0;
            inflight  <= '0;
            err_done  <= 1'b0;
        end else begin
            inflight <= inflight_next[CNT_WIDTH-1:0];

            if (ap_done && (inflight == '0) && !launch) begin
                err_done <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (if_read) begin
                        token_out <= if_dout;
                        ap_start  <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // Hold ap_start and token_out until the PE accepts.
                    if (ap_ready) begin
                        if (if_read) begin
                            token_out <= if_dout;
                        end else begin
                            ap_start <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    ap_start <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef START_TOKEN_CONSUMER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            launch_cnt <= '0;
            done_cnt   <= '0;
        end else begin
            if (launch) begin
                launch_cnt <= launch_cnt + 32'd1;
            end
            if (done_dec) begin
                done_cnt <= done_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_start_token_consumer.sv
// ---------------------------------------------------------------------------
// tb_start_token_consumer
//
// Directed bench for start_token_consumer (MAX_INFLIGHT=2). A small token
// FIFO feeds the DUT; pops and accepted launches are tallied on each clock
// edge. Inputs change 2 time units after the rising edge and outputs are
// compared there (or 1 unit later for combinational if_read).
// With START_TOKEN_CONSUMER_STATS_EN defined, a second MAX_INFLIGHT=4
// instance exercises the statistics counters.
// ---------------------------------------------------------------------------
module tb_start_token_consumer;

    logic       clk;
    logic       reset;
    logic       if_empty_n;
    logic       if_read;
    logic [0:0] if_dout;
    logic       ap_start;
    logic       ap_ready;
    logic       ap_done;
    logic [0:0] token_out;
    logic [3:0] inflight;
    logic       idle;
    logic       err_done;
`ifdef START_TOKEN_CONSUMER_STATS_EN
    logic [31:0] launch_cnt;
    logic [31:0] done_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Token FIFO model.
    logic [0:0] tok_mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         pops   = 0;
    int         launches = 0;

    assign if_empty_n = (rd_ptr != wr_ptr);
    assign if_dout    = tok_mem[rd_ptr];

    always @(posedge clk) begin
        if (if_read) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
        if (ap_start && ap_ready) begin
            launches <= launches + 1;
        end
    end

    start_token_consumer #(
        .DATA_WIDTH   (1),
        .MAX_INFLIGHT (2),
        .CNT_WIDTH    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_empty_n (if_empty_n),
        .if_read    (if_read),
        .if_dout    (if_dout),
        .ap_start   (ap_start),
        .ap_ready   (ap_ready),
        .ap_done    (ap_done),
        .token_out  (token_out),
        .inflight   (inflight),
        .idle       (idle),
        .err_done   (err_done)
`ifdef START_TOKEN_CONSUMER_STATS_EN
        ,
        .launch_cnt (launch_cnt),
        .done_cnt   (done_cnt)
`endif
    );

`ifdef START_TOKEN_CONSUMER_STATS_EN
    logic        s_empty_n;
    logic        s_read;
    logic [0:0]  s_dout;
    logic        s_start;
    logic        s_ready;
    logic        s_done;
    logic [0:0]  s_token;
    logic [3:0]  s_inflight;
    logic        s_idle;
    logic        s_err;
    logic [31:0] s_launch_cnt;
    logic [31:0] s_done_cnt;

    start_token_consumer #(
        .DATA_WIDTH   (1),
        .MAX_INFLIGHT (4),
        .CNT_WIDTH    (4)
    ) dut_stats (
        .clk        (clk),
        .reset      (reset),
        .if_empty_n (s_empty_n),
        .if_read    (s_read),
        .if_dout    (s_dout),
        .ap_start   (s_start),
        .ap_ready   (s_ready),
        .ap_done    (s_done),
        .token_out  (s_token),
        .inflight   (s_inflight),
        .idle       (s_idle),
        .err_done   (s_err),
        .launch_cnt (s_launch_cnt),
        .done_cnt   (s_done_cnt)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [0:0] t);
        tok_mem[wr_ptr] = t;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [0:0] exp_tok [0:3];
    int         hi_cnt;

    initial begin
        reset    = 1'b1;
        ap_ready = 1'b0;
        ap_done  = 1'b0;
`ifdef START_TOKEN_CONSUMER_STATS_EN
        s_empty_n = 1'b0;
        s_dout    = 1'b1;
        s_ready   = 1'b1;
        s_done    = 1'b0;
`endif
        exp_tok[0] = 1'b1;
        exp_tok[1] = 1'b1;
        exp_tok[2] = 1'b0;
        exp_tok[3] = 1'b1;

        // Reset state.
        step();
        step();
        check("rst_ap_start",  32'(ap_start),  32'd0);
        check("rst_token_out", 32'(token_out), 32'd0);
        check("rst_inflight",  32'(inflight),  32'd0);
        check("rst_err_done",  32'(err_done),  32'd0);
        check("rst_idle",      32'(idle),      32'd1);
        check("rst_if_read",   32'(if_read),   32'd0);
        reset = 1'b0;
        step();

        // Single token, ready after a wait, done 5 cycles later.
        push(1'b1);
        #1;
        check("s1_if_read_pop", 32'(if_read), 32'd1);
        step();
        check("s1_pops_1", 32'(pops), 32'd1);
        hi_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (ap_start) hi_cnt++;
            if (i == 3) ap_ready = 1'b1;
            step();
        end
        ap_ready = 1'b0;
        check("s1_start_cycles", 32'(hi_cnt),    32'd4);
        check("s1_start_low",    32'(ap_start),  32'd0);
        check("s1_token",        32'(token_out), 32'd1);
        check("s1_inflight_1",   32'(inflight),  32'd1);
        check("s1_not_idle",     32'(idle),      32'd0);
        check("s1_launches",     32'(launches),  32'd1);
        for (int i = 0; i < 4; i++) step();
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        check("s1_inflight_0", 32'(inflight), 32'd0);
        check("s1_idle",       32'(idle),     32'd1);
        check("s1_pops_once",  32'(pops),     32'd1);
        check("s1_no_err",     32'(err_done), 32'd0);

        // Four tokens, ready tied high, no done: capped at two launches.
        ap_ready = 1'b1;
        push(1'b1);
        push(1'b0);
        push(1'b1);
        push(1'b0);
        for (int i = 0; i < 5; i++) step();
        check("s2_pops",     32'(pops),      32'd3);
        check("s2_launches", 32'(launches),  32'd3);
        check("s2_inflight", 32'(inflight),  32'd2);
        check("s2_start",    32'(ap_start),  32'd0);
        check("s2_token",    32'(token_out), 32'd0);
        #1;
        check("s2_read_blocked", 32'(if_read), 32'd0);
        ap_done = 1'b1;
        #1;
        check("s2_read_on_done", 32'(if_read), 32'd1);
        step();
        ap_done = 1'b0;
        check("s2_pops_3rd",     32'(pops),      32'd4);
        check("s2_inflight_dn",  32'(inflight),  32'd1);
        check("s2_token_3rd",    32'(token_out), 32'd1);
        check("s2_start_3rd",    32'(ap_start),  32'd1);
        step();
        check("s2_inflight_cap", 32'(inflight),  32'd2);
        check("s2_start_drop",   32'(ap_start),  32'd0);
        check("s2_launches_3rd", 32'(launches),  32'd4);

        // Full throughput: launch and done every cycle at inflight=1.
        push(exp_tok[0]);
        push(exp_tok[1]);
        push(exp_tok[2]);
        push(exp_tok[3]);
        ap_done = 1'b1;
        step();
        check("s3_prime_inflight", 32'(inflight),  32'd1);
        check("s3_prime_start",    32'(ap_start),  32'd1);
        check("s3_prime_token",    32'(token_out), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("s3_bb_start",    32'(ap_start),  32'd1);
            check("s3_bb_inflight", 32'(inflight),  32'd1);
            check("s3_bb_token",    32'(token_out), 32'(exp_tok[k]));
        end
        step();
        check("s3_drain_start",    32'(ap_start), 32'd0);
        check("s3_drain_inflight", 32'(inflight), 32'd1);
        check("s3_launches",       32'(launches), 32'd9);
        check("s3_pops",           32'(pops),     32'd9);
        ap_ready = 1'b0;
        step();
        ap_done = 1'b0;
        check("s3_inflight_0", 32'(inflight), 32'd0);
        check("s3_idle",       32'(idle),     32'd1);
        check("s3_no_err",     32'(err_done), 32'd0);

        // Spurious done with nothing in flight.
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        check("s4_err_set",  32'(err_done), 32'd1);
        check("s4_inflight", 32'(inflight), 32'd0);
        step();
        check("s4_err_sticky", 32'(err_done), 32'd1);

        // Reset while a launch is pending and the FIFO holds a token.
        ap_ready = 1'b1;
        push(1'b1);
        step();
        step();
        ap_ready = 1'b0;
        push(1'b0);
        push(1'b1);
        step();
        step();
        check("s5_pend_start",    32'(ap_start),  32'd1);
        check("s5_pend_inflight", 32'(inflight),  32'd1);
        check("s5_pend_token",    32'(token_out), 32'd0);
        check("s5_pops_before",   32'(pops),      32'd11);
        reset = 1'b1;
        #1;
        check("s5_no_read_in_rst", 32'(if_read), 32'd0);
        step();
        check("s5_rst_start",    32'(ap_start),  32'd0);
        check("s5_rst_inflight", 32'(inflight),  32'd0);
        check("s5_rst_err",      32'(err_done),  32'd0);
        check("s5_rst_token",    32'(token_out), 32'd0);
        check("s5_rst_idle",     32'(idle),      32'd1);
        step();
        check("s5_rst_no_pop", 32'(pops), 32'd11);
        reset = 1'b0;
        #1;
        check("s5_read_after", 32'(if_read), 32'd1);
        step();
        check("s5_pop_after",   32'(pops),      32'd12);
        check("s5_token_after", 32'(token_out), 32'd1);
        check("s5_start_after", 32'(ap_start),  32'd1);
        ap_ready = 1'b1;
        step();
        ap_ready = 1'b0;
        check("s5_launch_after",   32'(launches), 32'd11);
        check("s5_inflight_after", 32'(inflight), 32'd1);

`ifdef START_TOKEN_CONSUMER_STATS_EN
        // Ten launches, seven completions on the MAX_INFLIGHT=4 instance.
        for (int i = 0; i < 10; i++) begin
            s_empty_n = 1'b1;
            step();
            s_empty_n = 1'b0;
            step();
            if (i < 7) begin
                s_done = 1'b1;
                step();
                s_done = 1'b0;
            end
        end
        step();
        check("st_launch_cnt", s_launch_cnt,       32'd10);
        check("st_done_cnt",   s_done_cnt,         32'd7);
        check("st_inflight",   32'(s_inflight),    32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
